// File: rtl/rotozoom_addr_gen.sv
// Rotozoom texture-address generator: maps raster position to texel coordinates under a
// per-frame rotation and zoom. Frame parameters are sampled on the vsync falling edge and
// turned into strides and a frame origin by a four-state sequencer; the pixel path then
// produces one texel address per clock with one cycle of latency.
module rotozoom_addr_gen #(
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned TEX_BITS = 7,
  parameter int unsigned ACC_W    = FRAC_W + TEX_BITS + 8,
  parameter int unsigned CENTRE_X = 320,
  parameter int unsigned CENTRE_Y = 240
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync,
  input  logic                active,
  input  logic [9:0]          x_px,
  input  logic signed [15:0]  sin_val,
  input  logic signed [15:0]  cos_val,
  input  logic [15:0]         scale,
  input  logic [1:0]          mode,
  output logic [TEX_BITS-1:0] tex_x,
  output logic [TEX_BITS-1:0] tex_y,
  output logic                tex_valid,
  output logic                tex_border,
  output logic                busy
);

  localparam int unsigned ShiftAmt = 22 - FRAC_W;
  localparam int unsigned TiW      = ACC_W - FRAC_W;
  localparam logic signed [ACC_W-1:0] CentreX = ACC_W'(CENTRE_X);
  localparam logic signed [ACC_W-1:0] CentreY = ACC_W'(CENTRE_Y);

  typedef enum logic [2:0] {StIdle, StStride, StOffX, StOffY, StLoad} state_e;

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     prev_vsync_q, prev_vsync_d;
  // Set once a LOAD has produced a coherent origin; blocks output after reset.
  logic                     params_ok_q, params_ok_d;
  logic signed [15:0]       sin_q, sin_d, cos_q, cos_d;
  logic [15:0]              scale_q, scale_d;
  logic [1:0]               mode_q, mode_d;
  logic signed [ACC_W-1:0]  du_dx_q, du_dx_d, dv_dx_q, dv_dx_d;
  logic signed [ACC_W-1:0]  ox_u_q, ox_u_d, ox_v_q, ox_v_d, oy_u_q, oy_u_d, oy_v_q, oy_v_d;
  logic signed [ACC_W-1:0]  u_row_q, u_row_d, v_row_q, v_row_d;
  logic signed [ACC_W-1:0]  u_acc_q, u_acc_d, v_acc_q, v_acc_d;
  logic [TEX_BITS-1:0]      tex_x_q, tex_x_d, tex_y_q, tex_y_d;
  logic                     tex_valid_q, tex_valid_d, tex_border_q, tex_border_d;

  logic                     tick;
  logic signed [32:0]       prod_c, prod_s;
  logic signed [ACC_W-1:0]  cur_u, cur_v;
  logic [TiW-1:0]           ti_u, ti_v;
  logic                     oob_u, oob_v, mode_clamp, mode_border;

  // Wrap takes the low bits; clamp saturates negatives to 0 and overflows to all ones.
  function automatic logic [TEX_BITS-1:0] map_axis(input logic [TiW-1:0] ti, input logic clamp,
                                                   input logic oob);
    if (clamp && oob) return ti[TiW-1] ? '0 : '1;
    return ti[TEX_BITS-1:0];
  endfunction

  // Sequencer, parameter shadowing and pixel path next-state logic.
  always_comb begin
    state_d      = state_q;
    prev_vsync_d = vsync;
    params_ok_d  = params_ok_q;
    sin_d        = sin_q;
    cos_d        = cos_q;
    scale_d      = scale_q;
    mode_d       = mode_q;
    du_dx_d      = du_dx_q;
    dv_dx_d      = dv_dx_q;
    ox_u_d       = ox_u_q;
    ox_v_d       = ox_v_q;
    oy_u_d       = oy_u_q;
    oy_v_d       = oy_v_q;
    u_row_d      = u_row_q;
    v_row_d      = v_row_q;
    u_acc_d      = u_acc_q;
    v_acc_d      = v_acc_q;
    tex_x_d      = tex_x_q;
    tex_y_d      = tex_y_q;
    tex_valid_d  = 1'b0;
    tex_border_d = 1'b0;

    tick   = prev_vsync_q & ~vsync;
    // Q8.8 unsigned times Q1.14 signed gives Q.22; shift down to FRAC_W fraction bits.
    prod_c = $signed({1'b0, scale_q}) * cos_q;
    prod_s = $signed({1'b0, scale_q}) * sin_q;

    cur_u       = (x_px == '0) ? u_row_q : u_acc_q;
    cur_v       = (x_px == '0) ? v_row_q : v_acc_q;
    ti_u        = cur_u[ACC_W-1:FRAC_W];
    ti_v        = cur_v[ACC_W-1:FRAC_W];
    // Any set bit above the texel field means negative or past the last texel.
    oob_u       = (ti_u[TiW-1:TEX_BITS] != '0);
    oob_v       = (ti_v[TiW-1:TEX_BITS] != '0);
    mode_clamp  = (mode_q == 2'd1);
    mode_border = (mode_q == 2'd2);

    case (state_q)
      StStride: begin
        du_dx_d = ACC_W'(prod_c >>> ShiftAmt);
        dv_dx_d = ACC_W'(prod_s >>> ShiftAmt);
        state_d = StOffX;
      end
      StOffX: begin
        ox_u_d  = CentreX * du_dx_q;
        ox_v_d  = CentreX * dv_dx_q;
        state_d = StOffY;
      end
      StOffY: begin
        oy_u_d  = CentreY * du_dx_q;
        oy_v_d  = CentreY * dv_dx_q;
        state_d = StLoad;
      end
      StLoad: begin
        // Origin of screen (0,0); line step is (-dv_dx, du_dx).
        u_row_d     = oy_v_q - ox_u_q;
        v_row_d     = -ox_v_q - oy_u_q;
        params_ok_d = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        if (active && params_ok_q) begin
          if (x_px == '0) begin
            u_acc_d = u_row_q + du_dx_q;
            v_acc_d = v_row_q + dv_dx_q;
            u_row_d = u_row_q - dv_dx_q;
            v_row_d = v_row_q + du_dx_q;
          end else begin
            u_acc_d = u_acc_q + du_dx_q;
            v_acc_d = v_acc_q + dv_dx_q;
          end
          tex_x_d      = map_axis(ti_u, mode_clamp, oob_u);
          tex_y_d      = map_axis(ti_v, mode_clamp, oob_v);
          tex_valid_d  = 1'b1;
          tex_border_d = mode_border & (oob_u | oob_v);
        end
      end
    endcase

    // A tick always wins, including mid-sequence: relatch and restart.
    if (tick) begin
      sin_d   = sin_val;
      cos_d   = cos_val;
      scale_d = scale;
      mode_d  = mode;
      state_d = StStride;
    end

    busy_d = (state_d != StIdle);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      prev_vsync_q <= 1'b1;
      params_ok_q  <= 1'b0;
      sin_q        <= '0;
      cos_q        <= '0;
      scale_q      <= '0;
      mode_q       <= '0;
      du_dx_q      <= '0;
      dv_dx_q      <= '0;
      ox_u_q       <= '0;
      ox_v_q       <= '0;
      oy_u_q       <= '0;
      oy_v_q       <= '0;
      u_row_q      <= '0;
      v_row_q      <= '0;
      u_acc_q      <= '0;
      v_acc_q      <= '0;
      tex_x_q      <= '0;
      tex_y_q      <= '0;
      tex_valid_q  <= 1'b0;
      tex_border_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      prev_vsync_q <= prev_vsync_d;
      params_ok_q  <= params_ok_d;
      sin_q        <= sin_d;
      cos_q        <= cos_d;
      scale_q      <= scale_d;
      mode_q       <= mode_d;
      du_dx_q      <= du_dx_d;
      dv_dx_q      <= dv_dx_d;
      ox_u_q       <= ox_u_d;
      ox_v_q       <= ox_v_d;
      oy_u_q       <= oy_u_d;
      oy_v_q       <= oy_v_d;
      u_row_q      <= u_row_d;
      v_row_q      <= v_row_d;
      u_acc_q      <= u_acc_d;
      v_acc_q      <= v_acc_d;
      tex_x_q      <= tex_x_d;
      tex_y_q      <= tex_y_d;
      tex_valid_q  <= tex_valid_d;
      tex_border_q <= tex_border_d;
    end
  end

  assign tex_x      = tex_x_q;
  assign tex_y      = tex_y_q;
  assign tex_valid  = tex_valid_q;
  assign tex_border = tex_border_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rotozoom_addr_gen.sv
// Directed bench for rotozoom_addr_gen: hand-computed texel addresses for identity, rotation,
// zoom and each addressing mode, plus sequencer restart and reset behaviour.
module tb_rotozoom_addr_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               vsync;
  logic               active;
  logic [9:0]         x_px;
  logic signed [15:0] sin_val;
  logic signed [15:0] cos_val;
  logic [15:0]        scale;
  logic [1:0]         mode;
  logic [6:0]         tex_x;
  logic [6:0]         tex_y;
  logic               tex_valid;
  logic               tex_border;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rotozoom_addr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync),
    .active    (active),
    .x_px      (x_px),
    .sin_val   (sin_val),
    .cos_val   (cos_val),
    .scale     (scale),
    .mode      (mode),
    .tex_x     (tex_x),
    .tex_y     (tex_y),
    .tex_valid (tex_valid),
    .tex_border(tex_border),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle vsync pulse with new parameters, then wait (bounded) for the sequencer.
  task automatic new_frame(input logic signed [15:0] s, input logic signed [15:0] c,
                           input logic [15:0] sc, input logic [1:0] m);
    @(negedge clk);
    sin_val = s;
    cos_val = c;
    scale   = sc;
    mode    = m;
    active  = 1'b0;
    vsync   = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check_eq("frame_load_done", int'(busy), 0);
  endtask

  // Raster to (x,y): one x=0 pixel per preceding line, then x=0..x on line y.
  task automatic probe(input int x, input int y, output logic [6:0] tx, output logic [6:0] ty,
                       output logic v, output logic b);
    for (int l = 0; l < y; l++) begin
      @(negedge clk);
      active = 1'b1;
      x_px   = '0;
      @(negedge clk);
      active = 1'b0;
    end
    for (int i = 0; i <= x; i++) begin
      @(negedge clk);
      active = 1'b1;
      x_px   = 10'(i);
    end
    @(negedge clk);
    tx     = tex_x;
    ty     = tex_y;
    v      = tex_valid;
    b      = tex_border;
    active = 1'b0;
  endtask

  task automatic point(input string tag, input logic signed [15:0] s,
                       input logic signed [15:0] c, input logic [15:0] sc, input logic [1:0] m,
                       input int x, input int y, input int ex, input int ey, input int eb);
    logic [6:0] tx, ty;
    logic       v, b;
    new_frame(s, c, sc, m);
    probe(x, y, tx, ty, v, b);
    check_eq({tag, "_valid"}, int'(v), 1);
    check_eq({tag, "_x"}, int'(tx), ex);
    check_eq({tag, "_y"}, int'(ty), ey);
    check_eq({tag, "_border"}, int'(b), eb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] tx, ty;
    logic       v, b;
    rst     = 1'b1;
    vsync   = 1'b1;
    active  = 1'b0;
    x_px    = '0;
    sin_val = '0;
    cos_val = 16'sd16384;
    scale   = 16'd256;
    mode    = 2'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", int'(tex_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_tex_x", int'(tex_x), 0);
    check_eq("rst_tex_y", int'(tex_y), 0);
    check_eq("rst_border", int'(tex_border), 0);
    rst = 1'b0;

    // No frame loaded yet: active pixels must not produce valid output.
    probe(3, 0, tx, ty, v, b);
    check_eq("noload_valid", int'(v), 0);

    // Identity: u = x-320, v = y-240.
    point("id_c", 16'sd0, 16'sd16384, 16'd256, 2'd0, 320, 240, 0, 0, 0);
    point("id_c1", 16'sd0, 16'sd16384, 16'd256, 2'd0, 321, 240, 1, 0, 0);
    point("id_org", 16'sd0, 16'sd16384, 16'd256, 2'd0, 0, 0, 64, 16, 0);
    point("id_mode3", 16'sd0, 16'sd16384, 16'd256, 2'd3, 0, 0, 64, 16, 0);
    // Rotate 90: u = 240-y, v = x-320.
    point("rot_a", 16'sd16384, 16'sd0, 16'd256, 2'd0, 321, 240, 0, 1, 0);
    point("rot_b", 16'sd16384, 16'sd0, 16'd256, 2'd0, 320, 241, 127, 0, 0);
    // Clamp and border.
    point("clamp_lo", 16'sd0, 16'sd16384, 16'd256, 2'd1, 0, 0, 0, 0, 0);
    point("clamp_hi", 16'sd0, 16'sd16384, 16'd256, 2'd1, 639, 479, 127, 127, 0);
    point("bord_out", 16'sd0, 16'sd16384, 16'd256, 2'd2, 0, 0, 64, 16, 1);
    point("bord_in", 16'sd0, 16'sd16384, 16'd256, 2'd2, 320, 240, 0, 0, 0);
    // Zoom: scale 2.0 gives u = 2*(x-320), scale 0.5 gives u = (x-320)/2.
    point("zoom2", 16'sd0, 16'sd16384, 16'd512, 2'd0, 322, 240, 4, 0, 0);
    point("zoom_half", 16'sd0, 16'sd16384, 16'd128, 2'd0, 322, 240, 1, 0, 0);

    // Mode input change after LOAD is ignored until the next frame.
    new_frame(16'sd0, 16'sd16384, 16'd256, 2'd1);
    mode = 2'd0;
    probe(0, 0, tx, ty, v, b);
    check_eq("shadow_mode_x", int'(tx), 0);
    check_eq("shadow_mode_y", int'(ty), 0);

    // Second tick two cycles after the first restarts the sequencer with new parameters.
    @(negedge clk);
    sin_val = '0;
    cos_val = 16'sd16384;
    scale   = 16'd128;
    mode    = 2'd0;
    vsync   = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    check_eq("retick_busy_e0", int'(busy), 1);
    @(negedge clk);
    vsync = 1'b0;
    scale = 16'd256;
    check_eq("retick_busy_e1", int'(busy), 1);
    @(negedge clk);
    vsync = 1'b1;
    check_eq("retick_busy_e2", int'(busy), 1);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("retick_busy_e%0d", k), int'(busy), 1);
    end
    @(negedge clk);
    check_eq("retick_busy_e6", int'(busy), 0);
    probe(322, 240, tx, ty, v, b);
    check_eq("retick_valid", int'(v), 1);
    check_eq("retick_x", int'(tx), 2);
    check_eq("retick_y", int'(ty), 0);

    // Reset in the middle of a line.
    new_frame(16'sd0, 16'sd16384, 16'd256, 2'd0);
    @(negedge clk);
    active = 1'b1;
    x_px   = 10'd0;
    @(negedge clk);
    x_px = 10'd1;
    @(negedge clk);
    check_eq("pre_rst_valid", int'(tex_valid), 1);
    check_eq("pre_rst_x", int'(tex_x), 65);
    x_px = 10'd2;
    rst  = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", int'(tex_valid), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_x", int'(tex_x), 0);
    check_eq("mid_rst_y", int'(tex_y), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_px = 10'(i);
      @(negedge clk);
      check_eq($sformatf("post_rst_valid%0d", i), int'(tex_valid), 0);
    end
    active = 1'b0;
    point("post_rst_id", 16'sd0, 16'sd16384, 16'd256, 2'd0, 321, 240, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
